deserializer: RTL

//  Receive side of the serial link. Consumes the low-start / high-stop,
//  LSB-first frame that the serializer stage emits and rebuilds the WIDTH-bit word.

---
 rtl/deserializer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/deserializer.sv
// Receive side of the serial link: rebuilds WIDTH-bit words from low-start /
// high-stop LSB-first frames and holds them for a valid/rd reader.
module deserializer #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in,
   input  logic             rd,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] HALF_C = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
   localparam logic [BIT_W-1:0] TOP_C  = BIT_W'(WIDTH - 1);
   localparam logic [BIT_W-1:0] BONE_C = BIT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   state_t            state_r,   state_s;
   logic [CNT_W-1:0]  clk_cnt_r, clk_cnt_s;
   logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_s;
   logic [WIDTH-1:0]  shift_r,   shift_s;
   logic [WIDTH-1:0]  data_r,    data_s;
   logic              valid_r,   valid_s;
   logic              ferr_r,    ferr_s;
   logic              ovr_r,     ovr_s;
   logic              busy_r,    busy_s;
   logic              good_s;

   // Frame reception FSM: next state, counters and shift register.
   always_comb begin
      state_s   = state_r;
      clk_cnt_s = clk_cnt_r;
      bit_cnt_s = bit_cnt_r;
      shift_s   = shift_r;
      good_s    = 1'b0;
      ferr_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!in) begin
               // The detection edge is clock 0 of the start bit; with a
               // zero half-period it is also the start-bit sample.
               if (HALF_C == {CNT_W{1'b0}}) begin
                  state_s   = ST_DATA;
                  clk_cnt_s = {CNT_W{1'b0}};
                  bit_cnt_s = {BIT_W{1'b0}};
               end else begin
                  state_s   = ST_START;
                  clk_cnt_s = ONE_C;
               end
            end else begin
               clk_cnt_s = {CNT_W{1'b0}};
               bit_cnt_s = {BIT_W{1'b0}};
            end
         end
         ST_START: begin
            if (clk_cnt_r == HALF_C) begin
               clk_cnt_s = {CNT_W{1'b0}};
               bit_cnt_s = {BIT_W{1'b0}};
               if (!in) begin
                  state_s = ST_DATA;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               clk_cnt_s = clk_cnt_r + ONE_C;
            end
         end
         ST_DATA: begin
            if (clk_cnt_r == LAST_C) begin
               clk_cnt_s          = {CNT_W{1'b0}};
               shift_s[bit_cnt_r] = in;
               if (bit_cnt_r == TOP_C) begin
                  state_s   = ST_STOP;
                  bit_cnt_s = {BIT_W{1'b0}};
               end else begin
                  bit_cnt_s = bit_cnt_r + BONE_C;
               end
            end else begin
               clk_cnt_s = clk_cnt_r + ONE_C;
            end
         end
         ST_STOP: begin
            if (clk_cnt_r == LAST_C) begin
               clk_cnt_s = {CNT_W{1'b0}};
               if (in) begin
                  good_s  = 1'b1;
                  state_s = ST_IDLE;
               end else begin
                  ferr_s  = 1'b1;
                  state_s = ST_BREAK;
               end
            end else begin
               clk_cnt_s = clk_cnt_r + ONE_C;
            end
         end
         ST_BREAK: begin
            if (in) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_BREAK;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            clk_cnt_s = {CNT_W{1'b0}};
            bit_cnt_s = {BIT_W{1'b0}};
         end
      endcase
   end

   // Reader-side holding register, handshake and overrun tracking.
   always_comb begin
      data_s  = data_r;
      valid_s = valid_r;
      ovr_s   = ovr_r;
      if (good_s) begin
         // A new word always wins; a concurrent rd absorbs the old one.
         data_s  = shift_r;
         valid_s = 1'b1;
         if (rd) begin
            ovr_s = 1'b0;
         end else if (valid_r) begin
            ovr_s = 1'b1;
         end else begin
            ovr_s = ovr_r;
         end
      end else begin
         if (rd) begin
            ovr_s = 1'b0;
         end else begin
            ovr_s = ovr_r;
         end
         if (rd && valid_r) begin
            valid_s = 1'b0;
         end else begin
            valid_s = valid_r;
         end
      end
      busy_s = (state_s != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         clk_cnt_r <= {CNT_W{1'b0}};
         bit_cnt_r <= {BIT_W{1'b0}};
         shift_r   <= {WIDTH{1'b0}};
         data_r    <= {WIDTH{1'b0}};
         valid_r   <= 1'b0;
         ferr_r    <= 1'b0;
         ovr_r     <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         clk_cnt_r <= clk_cnt_s;
         bit_cnt_r <= bit_cnt_s;
         shift_r   <= shift_s;
         data_r    <= data_s;
         valid_r   <= valid_s;
         ferr_r    <= ferr_s;
         ovr_r     <= ovr_s;
         busy_r    <= busy_s;
      end
   end

   assign data      = data_r;
   assign valid     = valid_r;
   assign frame_err = ferr_r;
   assign overrun   = ovr_r;
   assign busy      = busy_r;

   deserializer_chk u_chk (
      .clock     (clock),
      .reset_n   (reset_n),
      .rd        (rd),
      .valid     (valid_r),
      .frame_err (ferr_r),
      .overrun   (ovr_r)
   );

endmodule

// Handshake invariants of the deserializer output side.
module deserializer_chk (
   input logic clock,
   input logic reset_n,
   input logic rd,
   input logic valid,
   input logic frame_err,
   input logic overrun
);

   a_ferr_pulse: assert property (@(posedge clock) disable iff (!reset_n)
      frame_err |=> !frame_err);

   a_ovr_valid: assert property (@(posedge clock) disable iff (!reset_n)
      overrun |-> valid);

   a_valid_fall: assert property (@(posedge clock) disable iff (!reset_n)
      $fell(valid) |-> $past(rd));

endmodule
